// File: rtl/ad9228_tx_gearbox_if.sv
// Sample-word handshake between a word source and the AD9228 transmit gearbox.
interface ad9228_tx_gearbox_if #(
    parameter int unsigned DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/ad9228_tx_gearbox.sv
// 12-to-8 transmit gearbox emulating one AD9228 LVDS lane: MSB-first data bytes plus
// matching FCO bytes, with a 2-entry input FIFO and an optional fixed bit slip.
module ad9228_tx_gearbox #(
    parameter int unsigned           DATA_WIDTH = 12,
    parameter int unsigned           BIT_OFFSET = 0,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
    input  logic                      dco_div4,
    input  logic                      rst,
    input  logic                      tx_en,
    ad9228_tx_gearbox_if.slave        word_if,
    output logic [7:0]                data_byte,
    output logic [7:0]                fco_byte,
    output logic                      underflow,
    output logic [15:0]               underflow_count
);
    typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;

    phase_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  push, pop, empty, take;
    logic [DATA_WIDTH-1:0] head;

    logic [7:0]  r, p, fco_r, fco_p, hold;
    logic [7:0]  r_next, fco_next, hold_next;
    logic        uf_next;
    logic [15:0] uf_cnt;
    logic [15:0] data_cat, fco_cat;

    assign word_if.word_ready = !rst && (count < 2'd2);
    assign push  = word_if.word_valid && word_if.word_ready;
    assign empty = (count == 2'd0);
    assign head  = empty ? IDLE_WORD : mem[rd_ptr];

    // Phases 0 and 1 each consume one word slot; phase 2 flushes the held low byte.
    always_comb begin
        state_next = PH0;
        r_next     = '0;
        fco_next   = '0;
        hold_next  = hold;
        take       = 1'b0;
        if (tx_en) begin
            unique case (state)
                PH0: begin
                    state_next = PH1;
                    take       = 1'b1;
                    r_next     = head[11:4];
                    fco_next   = 8'hFC;
                    hold_next  = head[7:0];
                end
                PH1: begin
                    state_next = PH2;
                    take       = 1'b1;
                    r_next     = {hold[3:0], head[11:8]};
                    fco_next   = 8'h0F;
                    hold_next  = head[7:0];
                end
                default: begin
                    state_next = PH0;
                    r_next     = hold;
                    fco_next   = 8'hC0;
                end
            endcase
        end
        pop     = take && !empty;
        uf_next = take && empty;
    end

    always_ff @(posedge dco_div4) begin
        if (push) mem[wr_ptr] <= word_if.word_in;
    end

    always_ff @(posedge dco_div4 or posedge rst) begin
        if (rst) begin
            state     <= PH0;
            r         <= '0;
            p         <= '0;
            fco_r     <= '0;
            fco_p     <= '0;
            hold      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            underflow <= 1'b0;
            uf_cnt    <= '0;
        end else begin
            state     <= state_next;
            r         <= r_next;
            p         <= r;
            fco_r     <= fco_next;
            fco_p     <= fco_r;
            hold      <= hold_next;
            underflow <= uf_next;
            if (uf_next && (uf_cnt != '1)) uf_cnt <= uf_cnt + 16'd1;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // The slip window spans the previous and current byte, so offsets 0..7 stay static.
    assign data_cat        = {p, r};
    assign fco_cat         = {fco_p, fco_r};
    assign data_byte       = 8'(data_cat >> BIT_OFFSET);
    assign fco_byte        = 8'(fco_cat >> BIT_OFFSET);
    assign underflow_count = uf_cnt;
endmodule
